seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Consumes the 16-bit up/down counter value and overflow flag and drives a 4-digit
//  multiplexed 7-segment display in hex, plus a stretched overflow LED.
//  Sits directly downstream of the counter, between counter outputs and board pins.
//  Snapshots the count once per scan frame, so digits never tear mid-frame.
// PARAMETERS
//  REFRESH_DIV    50000  CLK cycles per digit slot; must be >= 1
//  OFLOW_HOLD     25000000  CLK cycles oFlowLed stays lit after an overflow pulse; must be >= 1
//  SEG_ACTIVE_LOW 1      1: seg/dp are driven low to light
//  AN_ACTIVE_LOW  1      1: an is driven low to select a digit
//  BLANK_LEADING  0      1: blank leading-zero digits (digit 0 is never blanked)
// PORTS
//  CLK       in   1   system clock; all logic is on posedge CLK
//  clear     in   1   synchronous, active-high reset
//  countIn   in   16  counter value; digit0 = [3:0], digit3 = [15:12]
//  oFlowIn   in   1   overflow flag from the counter; each high cycle is one event
//  enable    in   1   1: display on; 0: all digits dark, scan continues
//  seg       out  7   segments {g,f,e,d,c,b,a}
//  dp        out  1   decimal point
//  an        out  4   digit selects, one-hot (in the active sense)
//  oFlowLed  out  1   stretched overflow indicator, active-high
// BEHAVIOUR
//  - Reset (clear=1 at posedge): prescaler=0, digit index=0, snapshot=16'h0000, hold counter=0.
//    an/seg/dp are all inactive (all 1s when active-low) and oFlowLed=0. clear overrides every
//    other input in the same cycle, including oFlowIn.
//  - Prescaler: counts 0..REFRESH_DIV-1. tick=1 when it equals REFRESH_DIV-1; it then wraps to 0.
//    With REFRESH_DIV=1, tick fires every cycle.
//  - Digit index: 2-bit, advances on tick, 3 -> 0 wraps.
//  - Snapshot: on the tick where index goes 3->0, snapshot <= countIn. The first frame after
//    reset shows 0000.
//  - Outputs are registered. an/seg/dp update one cycle after tick. Digit k is displayed for
//    exactly REFRESH_DIV cycles.
//  - an: selects the current index. If enable=0, an is all inactive while the prescaler, index
//    and snapshot keep running.
//  - seg: hex decode of the selected snapshot nibble, using the standard 0-F glyphs
//    (b and d lowercase). Blanked when BLANK_LEADING=1, index>0, and the nibble plus all higher
//    nibbles are 0.
//  - dp: lit only on digit 0, and only while oFlowLed=1; otherwise off.
//  - Overflow stretch: oFlowIn=1 loads the hold counter with OFLOW_HOLD. Otherwise the counter
//    decrements while nonzero. oFlowLed = (hold != 0), registered, so it rises 1 cycle after
//    the oFlowIn edge and stays high exactly OFLOW_HOLD cycles. A re-trigger while lit restarts
//    the full hold. oFlowIn held high keeps the LED lit.
//  - countIn changes mid-frame have no effect until the next 3->0 wrap.
//  - clear asserted mid-scan: the next cycle shows reset state; the scan restarts at digit 0.
//  - Widths: prescaler is $clog2(REFRESH_DIV+1) bits and the hold counter is
//    $clog2(OFLOW_HOLD+1) bits; no truncation is allowed.
//  - Polarity is applied last via the *_ACTIVE_LOW parameters; internal logic is active-high.
// STRUCTURE
//  - Shared package seg7_pkg:
//    - 16-entry hex-to-segment constant table (active-high {g..a});
//    - SEG_BLANK = 7'h00;
//    - function hex2seg(nibble).
//  - Sub-module seg7_hex_decode: combinational nibble+blank -> 7-bit active-high segments;
//    reused by later display blocks.
//  - Top level holds the prescaler, index, snapshot, hold counter, blanking logic and output
//    registers.
// TESTING (REFRESH_DIV=4, OFLOW_HOLD=10, active-low, BLANK_LEADING=0 unless noted)
//  1. Hold clear 3 cycles, release -> an=4'b1111, seg=7'h7F, dp=1, oFlowLed=0 during clear;
//     first frame shows 0000.
//  2. countIn=16'hA3F0 steady -> second frame shows an=1110/seg(0), 1101/seg(F), 1011/seg(3),
//     0111/seg(A). Each select lasts 4 cycles.
//  3. Change countIn 16'h1234 -> 16'h5678 at digit 1 -> the rest of the frame shows 1234;
//     the next frame shows 5678.
//  4. 1-cycle oFlowIn pulse -> oFlowLed high 10 cycles starting 1 cycle later; dp lit only
//     while an=1110. Second pulse at cycle 6 -> LED stays high 10 more cycles from the retrigger.
//  5. BLANK_LEADING=1, countIn=16'h0040 -> digits 3 and 2 blank (seg=7'h7F), digit1 shows 4,
//     digit0 shows 0. countIn=0 -> only digit0 shows 0.
//  6. enable=0 for a frame, then 1; clear pulsed mid-frame -> an all 1 while disabled, scan
//     phase preserved; after clear, index=0, prescaler=0, LED off even if oFlowIn was high.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: hex glyph table, blank code, nibble decode helper.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package seg7_pkg;

    // Active-high segment pattern, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry [n] is the glyph for hex digit n; b and d are the lowercase forms.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71,  // F
        7'h79,  // E
        7'h5E,  // d
        7'h39,  // C
        7'h7C,  // b
        7'h77,  // A
        7'h6F,  // 9
        7'h7F,  // 8
        7'h07,  // 7
        7'h7D,  // 6
        7'h6D,  // 5
        7'h66,  // 4
        7'h4F,  // 3
        7'h5B,  // 2
        7'h06,  // 1
        7'h3F   // 0
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder with a blank override, active-high output.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg_dat
);

    // Blank wins over the glyph so callers can suppress leading zeros.
    always_comb begin
        seg_dat = blank ? SEG_BLANK : hex2seg(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed hex display driver with per-frame snapshot and stretched overflow LED.
// Latency: outputs registered, one cycle after the scan state / overflow input changes.
// Backpressure: none; countIn is sampled once per frame, oFlowIn on every cycle.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter int OFLOW_HOLD     = 25000000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int BLANK_LEADING  = 0
) (
    input  logic        CLK,
    input  logic        clear,
    input  logic [15:0] countIn,
    input  logic        oFlowIn,
    input  logic        enable,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        oFlowLed
);

    localparam int PW = $clog2(REFRESH_DIV + 1);
    localparam int HW = $clog2(OFLOW_HOLD + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(OFLOW_HOLD);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          led_q, led_d;

    logic          tick;
    logic [3:0]    cur_nib;
    logic          blank_lead;
    logic [6:0]    dec_seg;

    // Prescaler, digit index and frame snapshot; snapshot only moves on the 3->0 wrap.
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);
        idx_d   = tick ? idx_q + 2'd1 : idx_q;
        snap_d  = (tick && idx_q == 2'd3) ? countIn : snap_q;
    end

    // Overflow stretch: any oFlowIn cycle reloads the full hold, else count down to zero.
    always_comb begin
        if (oFlowIn) begin
            hold_d = HOLD_LOAD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
        end else begin
            hold_d = hold_q;
        end
    end

    // Select the current nibble and decide whether it is a suppressible leading zero.
    always_comb begin
        cur_nib    = 4'h0;
        blank_lead = 1'b0;
        case (idx_q)
            2'd0: cur_nib = snap_q[3:0];
            2'd1: begin
                cur_nib    = snap_q[7:4];
                blank_lead = (snap_q[15:4] == 12'h000);
            end
            2'd2: begin
                cur_nib    = snap_q[11:8];
                blank_lead = (snap_q[15:8] == 8'h00);
            end
            default: begin
                cur_nib    = snap_q[15:12];
                blank_lead = (snap_q[15:12] == 4'h0);
            end
        endcase
        if (BLANK_LEADING == 0) begin
            blank_lead = 1'b0;
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble  (cur_nib),
        .blank   (blank_lead),
        .seg_dat (dec_seg)
    );

    // Next output values, all active-high; LED and dp follow the post-update hold count.
    always_comb begin
        led_d = (hold_d != '0);
        an_d  = enable ? (4'b0001 << idx_q) : 4'b0000;
        seg_d = enable ? dec_seg : SEG_BLANK;
        dp_d  = enable && (idx_q == 2'd0) && led_d;
    end

    // State and output registers; clear beats every other input, including oFlowIn.
    always_ff @(posedge CLK) begin
        if (clear) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            snap_q  <= 16'h0000;
            hold_q  <= '0;
            an_q    <= 4'b0000;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            hold_q  <= hold_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            led_q   <= led_d;
        end
    end

    // Pin polarity is applied only here; everything upstream is active-high.
    assign an       = (AN_ACTIVE_LOW  != 0) ? ~an_q  : an_q;
    assign seg      = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign dp       = (SEG_ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
    assign oFlowLed = led_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios then random traffic vs an arithmetic model.
// Latency: checks one cycle of registered output after each clock edge.
// Backpressure: not applicable.
module tb_seg7_scan_driver;

    localparam int R = 4;
    localparam int H = 10;

    logic        CLK = 1'b0;
    logic        clear;
    logic [15:0] countIn;
    logic        oFlowIn;
    logic        enable;

    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [3:0]  an0, an1;
    logic        led0, led1;

    int tests = 0;
    int fails = 0;

    // Model state: n = clock edges since clear released, with the countIn seen at each.
    int          n;
    bit          have_ofl;
    int          last_ofl;
    logic        en_s;
    logic [15:0] hist [0:8191];

    always #5 CLK = ~CLK;

    seg7_scan_driver #(
        .REFRESH_DIV(R), .OFLOW_HOLD(H), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LEADING(0)
    ) dut (
        .CLK(CLK), .clear(clear), .countIn(countIn), .oFlowIn(oFlowIn), .enable(enable),
        .seg(seg0), .dp(dp0), .an(an0), .oFlowLed(led0)
    );

    seg7_scan_driver #(
        .REFRESH_DIV(R), .OFLOW_HOLD(H), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)
    ) dut_bl (
        .CLK(CLK), .clear(clear), .countIn(countIn), .oFlowIn(oFlowIn), .enable(enable),
        .seg(seg1), .dp(dp1), .an(an1), .oFlowLed(led1)
    );

    // Standard hex glyphs, active-high {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, exp, n);
        end
    endtask

    // One clock: advance the model with the inputs the DUT sampled, then compare.
    task automatic step();
        int          c;
        int          d;
        int          base;
        logic [15:0] snap;
        logic [15:0] upper;
        logic [3:0]  nib;
        logic [3:0]  sel;
        bit          led;
        bit          bl;
        logic [6:0]  exp_seg0;
        logic [6:0]  exp_seg1;
        @(posedge CLK);
        if (clear) begin
            n        = 0;
            have_ofl = 1'b0;
        end else begin
            n++;
            hist[n] = countIn;
            if (oFlowIn) begin
                have_ofl = 1'b1;
                last_ofl = n;
            end
        end
        en_s = enable;
        #1;
        if (n == 0) begin
            check("reset_an",  {4'h0, an0},  8'h0F);
            check("reset_seg", {1'b0, seg0}, 8'h7F);
            check("reset_dp",  {7'h0, dp0},  8'h01);
            check("reset_led", {7'h0, led0}, 8'h00);
            check("reset_an_bl", {4'h0, an1}, 8'h0F);
        end else begin
            c     = n - 1;
            d     = (c / R) % 4;
            base  = (c / (4 * R)) * (4 * R);
            snap  = (base == 0) ? 16'h0000 : hist[base];
            upper = snap >> (4 * d);
            nib   = upper[3:0];
            bl    = (d > 0) && (upper == 16'h0000);
            led   = have_ofl && ((n - last_ofl) < H);
            sel   = 4'b0001 << d;
            check("led",    {7'h0, led0}, {7'h0, led});
            check("led_bl", {7'h0, led1}, {7'h0, led});
            check("an",     {4'h0, an0},  en_s ? {4'h0, ~sel} : 8'h0F);
            check("an_bl",  {4'h0, an1},  en_s ? {4'h0, ~sel} : 8'h0F);
            if (en_s) begin
                exp_seg0 = ~glyph(nib);
                exp_seg1 = bl ? 7'h7F : ~glyph(nib);
                check("seg",    {1'b0, seg0}, {1'b0, exp_seg0});
                check("seg_bl", {1'b0, seg1}, {1'b0, exp_seg1});
                check("dp",     {7'h0, dp0},  {7'h0, ~(d == 0 && led)});
            end
        end
    endtask

    initial begin
        n        = 0;
        have_ofl = 1'b0;
        last_ofl = 0;
        en_s     = 1'b1;
        clear    = 1'b1;
        countIn  = 16'h0000;
        oFlowIn  = 1'b0;
        enable   = 1'b1;

        // Reset held three cycles, then first frame must show 0000.
        repeat (3) step();
        clear   = 1'b0;
        countIn = 16'hA3F0;
        repeat (3 * 4 * R) step();

        // Mid-frame countIn change must not tear the current frame.
        countIn = 16'h1234;
        repeat (4 * R) step();
        while (((n / R) % 4) != 1) step();
        countIn = 16'h5678;
        repeat (2 * 4 * R) step();

        // Overflow pulse and retrigger while lit.
        oFlowIn = 1'b1;
        step();
        oFlowIn = 1'b0;
        repeat (5) step();
        oFlowIn = 1'b1;
        step();
        oFlowIn = 1'b0;
        repeat (15) step();

        // Leading-zero blanking on the second instance.
        countIn = 16'h0040;
        repeat (2 * 4 * R) step();
        countIn = 16'h0000;
        repeat (2 * 4 * R) step();

        // Disable for a frame, then clear mid-frame with overflow active.
        countIn = 16'hBEEF;
        enable  = 1'b0;
        repeat (4 * R) step();
        enable  = 1'b1;
        repeat (6) step();
        oFlowIn = 1'b1;
        step();
        clear   = 1'b1;
        step();
        clear   = 1'b0;
        oFlowIn = 1'b0;
        repeat (4 * R + 2) step();

        // Random traffic with occasional clears.
        repeat (2000) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: countIn = 16'($urandom);
                    1: countIn = 16'($urandom) & 16'h00FF;
                    2: countIn = 16'($urandom) & 16'h000F;
                    default: countIn = 16'h0000;
                endcase
            end
            oFlowIn = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            clear = ($urandom_range(0, 299) == 0);
            step();
        end
        clear = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
